pipeline_hazard_controller: RTL and testbench
=============================================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter REG_AW, default 5: register-specifier width.
REQ-002 Parameter LOAD_STALL, default 1, legal 1..7: bubble cycles per load-use hazard (multi-cycle data memory).
REQ-003 Parameter CNT_W, default 16: StallCount width.
REQ-004 Clock  in  1: single clock; all state updates on its rising edge.
REQ-005 Reset  in  1: asynchronous, active-low.
REQ-006 MemReadFromIDEX  in  1: instruction in EX is a load.
REQ-007 EX_Rt  in  REG_AW: load destination register in EX.
REQ-008 ID_Rs, ID_Rt  in  REG_AW each: source registers of the instruction in ID.
REQ-009 ID_UsesRt  in  1: ID instruction reads Rt (R-type, store, branch).
REQ-010 BranchTakenEX  in  1: taken branch/jump resolved in EX this cycle.
REQ-011 MemBusy  in  1: data memory not ready; whole pipeline must freeze.
REQ-012 PC_WriteEnable  out  1: 1 = PC updates.
REQ-013 IFID_WriteEnable  out  1: 1 = IF/ID register loads.
REQ-014 WriteEnableMuxControl  out  1: 1 = ID control passes to ID/EX; 0 = zero controls (bubble).
REQ-015 IFID_Flush, IDEX_Flush  out  1 each: clear the named pipeline register at the next edge.
REQ-016 PipeHold  out  1: 1 = ID/EX, EX/MEM, MEM/WB hold contents.
REQ-017 StallCount  out  CNT_W: saturating count of bubble cycles inserted.

Function
REQ-018 LoadUse = MemReadFromIDEX & (EX_Rt != 0) & ((EX_Rt == ID_Rs) | (ID_UsesRt & (EX_Rt == ID_Rt))); register 0 never hazards.
REQ-019 FSM states: IDLE, STALL; 3-bit down-counter Remain.
REQ-020 Outputs combinational from state and inputs, same-cycle (Mealy); all other state registered.
REQ-021 Priority, highest first: MemBusy, BranchTakenEX, stall (STALL state or LoadUse in IDLE), normal.
REQ-022 MemBusy=1: PC_WriteEnable=0, IFID_WriteEnable=0, WriteEnableMuxControl=1, both flushes 0, PipeHold=1; state, Remain, StallCount hold.
REQ-023 BranchTakenEX=1, MemBusy=0: IFID_Flush=1, IDEX_Flush=1, PC_WriteEnable=1, IFID_WriteEnable=1, WriteEnableMuxControl=1, PipeHold=0; next state IDLE, Remain=0 (pending stall aborted); StallCount unchanged.
REQ-024 Stall cycle (IDLE with LoadUse, or STALL), no MemBusy/branch: PC_WriteEnable=0, IFID_WriteEnable=0, WriteEnableMuxControl=0, flushes 0, PipeHold=0; StallCount += 1, saturating at 2^CNT_W-1.
REQ-025 IDLE with LoadUse: if LOAD_STALL==1 stay IDLE; else go STALL, Remain=LOAD_STALL-1.
REQ-026 STALL: LoadUse ignored; Remain==1 -> IDLE, Remain=0; else Remain-=1.
REQ-027 Each load-use hazard yields exactly LOAD_STALL bubble cycles, excluding MemBusy cycles.
REQ-028 Normal cycle: all enables 1, flushes 0, PipeHold 0.
REQ-029 Back-to-back: LoadUse in IDLE the cycle after STALL exits starts a new stall sequence.

Reset
REQ-030 Reset low: state IDLE, Remain=0, StallCount=0 immediately, independent of Clock.
REQ-031 While Reset low: PC_WriteEnable=0, IFID_WriteEnable=0, WriteEnableMuxControl=0, flushes 0, PipeHold=0.
REQ-032 Reset deassertion mid-stall: first cycle after release evaluates from IDLE; no residual bubbles.

Verification
REQ-033 LOAD_STALL=1; lw EX_Rt=5, ID_Rs=5 -> one cycle enables 0/bubble, StallCount=1, then all enables 1.
REQ-034 LOAD_STALL=3; EX_Rt=7, ID_Rt=7, ID_UsesRt=1 -> 3 consecutive bubble cycles, StallCount=3; same with ID_UsesRt=0 -> no stall.
REQ-035 EX_Rt=0=ID_Rs, MemReadFromIDEX=1 -> no stall, StallCount=0.
REQ-036 LOAD_STALL=3, MemBusy=1 for 2 cycles during 2nd bubble -> PipeHold=1 for 2 cycles, 3 bubbles total, StallCount=3.
REQ-037 BranchTakenEX=1 coincident with LoadUse -> IFID_Flush=IDEX_Flush=1, no bubble, next cycle IDLE normal.
REQ-038 Reset low in STALL (Remain=2) -> all outputs 0 at once, StallCount=0; after release, normal cycle with all enables 1.

Source files
------------

// File: rtl/pipeline_hazard_controller_if.sv
// Sideband bundle between the pipeline datapath (master) and the hazard controller (slave).
// No valid/ready here: every cycle the datapath presents fresh ID/EX facts and the controller answers in that same cycle.
interface pipeline_hazard_controller_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              MemReadFromIDEX;
  logic [REG_AW-1:0] EX_Rt;
  logic [REG_AW-1:0] ID_Rs;
  logic [REG_AW-1:0] ID_Rt;
  logic              ID_UsesRt;
  logic              BranchTakenEX;
  logic              MemBusy;

  logic              PC_WriteEnable;
  logic              IFID_WriteEnable;
  logic              WriteEnableMuxControl;
  logic              IFID_Flush;
  logic              IDEX_Flush;
  logic              PipeHold;
  logic [CNT_W-1:0]  StallCount;

  modport master (
    output MemReadFromIDEX, EX_Rt, ID_Rs, ID_Rt, ID_UsesRt, BranchTakenEX, MemBusy,
    input  PC_WriteEnable, IFID_WriteEnable, WriteEnableMuxControl,
    input  IFID_Flush, IDEX_Flush, PipeHold, StallCount
  );

  modport slave (
    input  MemReadFromIDEX, EX_Rt, ID_Rs, ID_Rt, ID_UsesRt, BranchTakenEX, MemBusy,
    output PC_WriteEnable, IFID_WriteEnable, WriteEnableMuxControl,
    output IFID_Flush, IDEX_Flush, PipeHold, StallCount
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Load-use stall / branch flush / memory-freeze controller for a 5-stage pipeline.
// Outputs are Mealy (same-cycle); state, bubble countdown and bubble counter are registered.
module pipeline_hazard_controller #(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic                          Clock,
  input  logic                          Reset,
  pipeline_hazard_controller_if.slave   hz,
  output logic                          dbg_state
);

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL - 1);

  state_t     state;
  logic [2:0] remain;
  logic       load_use;
  logic       stall_cycle;

  // Register 0 is hardwired zero, so a load targeting it can never feed a consumer.
  assign load_use = hz.MemReadFromIDEX
                  & (hz.EX_Rt != REG_AW'(0))
                  & ((hz.EX_Rt == hz.ID_Rs) | (hz.ID_UsesRt & (hz.EX_Rt == hz.ID_Rt)));

  assign stall_cycle = (state == STALL) | ((state == IDLE) & load_use);
  assign dbg_state   = (state == STALL);

  always_comb begin
    hz.PC_WriteEnable        = 1'b0;
    hz.IFID_WriteEnable      = 1'b0;
    hz.WriteEnableMuxControl = 1'b0;
    hz.IFID_Flush            = 1'b0;
    hz.IDEX_Flush            = 1'b0;
    hz.PipeHold              = 1'b0;
    if (!Reset) begin
      hz.PC_WriteEnable = 1'b0;
    end else if (hz.MemBusy) begin
      hz.WriteEnableMuxControl = 1'b1;
      hz.PipeHold              = 1'b1;
    end else if (hz.BranchTakenEX) begin
      hz.PC_WriteEnable        = 1'b1;
      hz.IFID_WriteEnable      = 1'b1;
      hz.WriteEnableMuxControl = 1'b1;
      hz.IFID_Flush            = 1'b1;
      hz.IDEX_Flush            = 1'b1;
    end else if (stall_cycle) begin
      hz.PC_WriteEnable = 1'b0;
    end else begin
      hz.PC_WriteEnable        = 1'b1;
      hz.IFID_WriteEnable      = 1'b1;
      hz.WriteEnableMuxControl = 1'b1;
    end
  end

  // A frozen memory cycle holds everything so it never consumes one of the bubbles.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state         <= IDLE;
      remain        <= 3'd0;
      hz.StallCount <= '0;
    end else if (hz.MemBusy) begin
      state         <= state;
      remain        <= remain;
      hz.StallCount <= hz.StallCount;
    end else if (hz.BranchTakenEX) begin
      state  <= IDLE;
      remain <= 3'd0;
    end else if (stall_cycle) begin
      if (hz.StallCount != {CNT_W{1'b1}}) begin
        hz.StallCount <= hz.StallCount + 1'b1;
      end
      if (state == IDLE) begin
        if (LOAD_STALL == 1) begin
          state  <= IDLE;
          remain <= 3'd0;
        end else begin
          state  <= STALL;
          remain <= STALL_INIT;
        end
      end else if (remain == 3'd1) begin
        state  <= IDLE;
        remain <= 3'd0;
      end else begin
        remain <= remain - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for the hazard controller: one instance with single-cycle loads and a 2-bit counter,
// one with three-cycle loads; a monitor compares each cycle against queued hand-computed responses.
module tb_pipeline_hazard_controller;

  localparam int W = 23;

  // {PC_WE, IFID_WE, WEMux, IFID_Flush, IDEX_Flush, PipeHold}
  localparam logic [5:0] O_NORM = 6'b111000;
  localparam logic [5:0] O_BUBL = 6'b000000;
  localparam logic [5:0] O_BUSY = 6'b001001;
  localparam logic [5:0] O_BRAN = 6'b111110;
  localparam logic [5:0] O_RST  = 6'b000000;

  logic Clock;
  logic Reset;
  logic dbg1;
  logic dbg3;

  logic [W-1:0] exp1_q[$];
  logic [W-1:0] exp3_q[$];
  string        name1_q[$];
  string        name3_q[$];

  int n_cmp;
  int n_bad;

  pipeline_hazard_controller_if #(.REG_AW(5), .CNT_W(2))  if1 ();
  pipeline_hazard_controller_if #(.REG_AW(5), .CNT_W(16)) if3 ();

  pipeline_hazard_controller #(.REG_AW(5), .LOAD_STALL(1), .CNT_W(2)) dut1 (
    .Clock(Clock), .Reset(Reset), .hz(if1.slave), .dbg_state(dbg1)
  );

  pipeline_hazard_controller #(.REG_AW(5), .LOAD_STALL(3), .CNT_W(16)) dut3 (
    .Clock(Clock), .Reset(Reset), .hz(if3.slave), .dbg_state(dbg3)
  );

  // Clock and reset
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    Reset = 1'b0;
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: new inputs land just after a rising edge; the response for that cycle is queued.
  task automatic drive(input int sel, input bit rst, input bit mr, input int ex, input int rs,
                       input int rt, input bit uses, input bit br, input bit busy,
                       input logic [5:0] o, input bit st, input int cnt, input string name);
    logic [W-1:0] e;
    @(posedge Clock);
    #1;
    Reset = rst;
    if1.MemReadFromIDEX = (sel & 1) ? mr   : 1'b0;
    if1.EX_Rt           = (sel & 1) ? 5'(ex) : 5'd0;
    if1.ID_Rs           = (sel & 1) ? 5'(rs) : 5'd0;
    if1.ID_Rt           = (sel & 1) ? 5'(rt) : 5'd0;
    if1.ID_UsesRt       = (sel & 1) ? uses : 1'b0;
    if1.BranchTakenEX   = (sel & 1) ? br   : 1'b0;
    if1.MemBusy         = (sel & 1) ? busy : 1'b0;
    if3.MemReadFromIDEX = (sel & 2) ? mr   : 1'b0;
    if3.EX_Rt           = (sel & 2) ? 5'(ex) : 5'd0;
    if3.ID_Rs           = (sel & 2) ? 5'(rs) : 5'd0;
    if3.ID_Rt           = (sel & 2) ? 5'(rt) : 5'd0;
    if3.ID_UsesRt       = (sel & 2) ? uses : 1'b0;
    if3.BranchTakenEX   = (sel & 2) ? br   : 1'b0;
    if3.MemBusy         = (sel & 2) ? busy : 1'b0;
    e = {o, st, 16'(cnt)};
    if (sel & 1) begin
      exp1_q.push_back(e);
      name1_q.push_back(name);
    end
    if (sel & 2) begin
      exp3_q.push_back(e);
      name3_q.push_back(name);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, mid-cycle.
  initial begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    string        nm;
    forever begin
      @(negedge Clock);
      if (exp1_q.size() > 0) begin
        e  = exp1_q.pop_front();
        nm = name1_q.pop_front();
        act = {if1.PC_WriteEnable, if1.IFID_WriteEnable, if1.WriteEnableMuxControl,
               if1.IFID_Flush, if1.IDEX_Flush, if1.PipeHold, dbg1, 16'(if1.StallCount)};
        n_cmp++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL dut1 %s: got out=%b st=%b cnt=%0d, want out=%b st=%b cnt=%0d",
                   nm, act[22:17], act[16], act[15:0], e[22:17], e[16], e[15:0]);
        end
      end
      if (exp3_q.size() > 0) begin
        e  = exp3_q.pop_front();
        nm = name3_q.pop_front();
        act = {if3.PC_WriteEnable, if3.IFID_WriteEnable, if3.WriteEnableMuxControl,
               if3.IFID_Flush, if3.IDEX_Flush, if3.PipeHold, dbg3, if3.StallCount};
        n_cmp++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL dut3 %s: got out=%b st=%b cnt=%0d, want out=%b st=%b cnt=%0d",
                   nm, act[22:17], act[16], act[15:0], e[22:17], e[16], e[15:0]);
        end
      end
    end
  end

  initial begin
    bit drained;
    n_cmp = 0;
    n_bad = 0;

    //    sel rst mr ex rs rt us br bz  out     st cnt  name
    drive(3, 0, 0, 0, 0, 0, 0, 0, 0, O_RST,  0, 0, "reset_state");
    drive(3, 1, 0, 0, 0, 0, 0, 0, 0, O_NORM, 0, 0, "first_normal");

    // Single-cycle loads and counter saturation on the 2-bit instance
    drive(1, 1, 1, 5, 5, 0, 0, 0, 0, O_BUBL, 0, 0, "ls1_bubble");
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, O_NORM, 0, 1, "ls1_resume");
    drive(1, 1, 1, 5, 5, 0, 0, 0, 0, O_BUBL, 0, 1, "sat_b1");
    drive(1, 1, 1, 5, 5, 0, 0, 0, 0, O_BUBL, 0, 2, "sat_b2");
    drive(1, 1, 1, 5, 5, 0, 0, 0, 0, O_BUBL, 0, 3, "sat_b3");
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, O_NORM, 0, 3, "sat_hold");

    // Three-cycle loads
    drive(2, 1, 1, 0, 0, 0, 0, 0, 0, O_NORM, 0, 0, "r0_no_hazard");
    drive(2, 1, 1, 7, 3, 7, 0, 0, 0, O_NORM, 0, 0, "rt_unused");
    drive(2, 1, 1, 7, 3, 7, 1, 0, 0, O_BUBL, 0, 0, "rt_bub1");
    drive(2, 1, 1, 7, 3, 7, 1, 0, 0, O_BUBL, 1, 1, "rt_bub2");
    drive(2, 1, 1, 7, 3, 7, 1, 0, 0, O_BUBL, 1, 2, "rt_bub3");
    drive(2, 1, 0, 0, 0, 0, 0, 0, 0, O_NORM, 0, 3, "rt_resume");

    drive(2, 1, 1, 9, 9, 0, 0, 0, 0, O_BUBL, 0, 3, "busy_bub1");
    drive(2, 1, 1, 9, 9, 0, 0, 0, 1, O_BUSY, 1, 4, "busy_f1");
    drive(2, 1, 1, 9, 9, 0, 0, 0, 1, O_BUSY, 1, 4, "busy_f2");
    drive(2, 1, 1, 9, 9, 0, 0, 0, 0, O_BUBL, 1, 4, "busy_bub2");
    drive(2, 1, 1, 9, 9, 0, 0, 0, 0, O_BUBL, 1, 5, "busy_bub3");
    drive(2, 1, 1, 4, 4, 0, 0, 0, 0, O_BUBL, 0, 6, "b2b_bub1");
    drive(2, 1, 1, 4, 4, 0, 0, 1, 0, O_BRAN, 1, 7, "branch_in_stall");
    drive(2, 1, 0, 0, 0, 0, 0, 0, 0, O_NORM, 0, 7, "after_abort");
    drive(2, 1, 1, 6, 6, 0, 0, 1, 0, O_BRAN, 0, 7, "branch_loaduse");
    drive(2, 1, 0, 0, 0, 0, 0, 0, 0, O_NORM, 0, 7, "after_branch");

    drive(2, 1, 1, 6, 6, 0, 0, 0, 1, O_BUSY, 0, 7, "busy_idle_lu");
    drive(2, 1, 1, 6, 6, 0, 0, 0, 0, O_BUBL, 0, 7, "rst_bub1");
    drive(3, 0, 1, 6, 6, 0, 0, 0, 0, O_RST,  0, 0, "async_reset");
    drive(3, 0, 1, 6, 6, 0, 0, 0, 0, O_RST,  0, 0, "reset_held");
    drive(3, 1, 0, 0, 0, 0, 0, 0, 0, O_NORM, 0, 0, "post_reset1");
    drive(3, 1, 0, 0, 0, 0, 0, 0, 0, O_NORM, 0, 0, "post_reset2");

    drained = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      #1;
      if (exp1_q.size() == 0 && exp3_q.size() == 0) begin
        drained = 1'b1;
        break;
      end
    end
    if (!drained) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d pending, want 0/0", exp1_q.size(), exp3_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
